trace_replay: RTL and testbench
===============================

// Module: trace_replay
// PURPOSE
// - Playback counterpart of the trace capture path: host pushes captured entries back as 32-bit bus words,
//   block reassembles them into width-bit entries, stores them in an internal BRAM, then on command
//   replays them as an enable/data stream matching the capture side's TraceIfc client signals.
// - Sits between the host bus (indication/request FIFOs) and the DUT stimulus port under test.
// PARAMETERS
// - depth   1024  entries in replay buffer; power of two
// - width   64    replayed entry width; must be a multiple of owidth
// - owidth  32    host bus word width
// PORTS
// - CLK            in   1                   single clock
// - RST            in   1                   synchronous reset, active-high
// - in.enq__ENA    in   1                   host word valid
// - in.enq$v       in   owidth              host word, least-significant chunk first
// - in.enq__RDY    out  1                   block accepts a word this cycle
// - start__ENA     in   1                   begin replay
// - start$count    in   $clog2(depth)+1     entries to replay, 1..depth
// - start$gap      in   8                   idle cycles inserted between entries
// - start__RDY     out  1                   high only in IDLE with loaded>0
// - enable         out  1                   replayed entry valid (1-cycle pulse per entry)
// - data           out  width               replayed entry, held until next entry
// - done           out  1                   1-cycle pulse after last entry
// - loaded         out  $clog2(depth)+1     entries currently stored
// BEHAVIOUR
// - Reset: state=IDLE, enable=0, data=0, done=0, loaded=0, wptr=0, chunk count=0; buffer contents undefined.
// - Handshake: transfer occurs when __ENA && __RDY same cycle; __ENA without __RDY is ignored.
// - States: IDLE -> (start) -> REPLAY -> (count entries issued) -> DONE -> IDLE (1 cycle).
// - in.enq__RDY = (state==IDLE) && (loaded<depth) && bram$write__RDY.
// - Assembly: width/owidth words per entry; chunk k lands in bits [k*owidth +: owidth].
//   Last chunk triggers bram write at wptr, wptr++ (wraps mod depth), loaded++.
// - Full: loaded==depth -> in.enq__RDY=0; excess words are back-pressured, never dropped.
// - Partial entry pending at start: start__RDY=0 until entry complete.
// - REPLAY: rptr starts at 0; bram read issued at rptr, dataOut valid next cycle (1-cycle latency);
//   on dataOut: data<=dataOut, enable=1 that cycle, then wait gap cycles before next read.
//   gap=0 -> one entry per 2 cycles (read + emit); reads may be pipelined to 1/cycle only if gap==0.
// - count>loaded: clamp to loaded. count==0: treated as loaded.
// - rptr wraps mod depth; replay never reads beyond loaded entries.
// - DONE: done=1 for one cycle, then IDLE; buffer and loaded preserved (replay can be repeated).
// - Loading during REPLAY impossible (in.enq__RDY=0); start during REPLAY ignored (start__RDY=0).
// - Reset mid-replay: enable/done drop next cycle, loaded=0 (buffer logically cleared).
// - enable is never high in the same cycle as done.
// STRUCTURE
// - Shared package: replay_state_t {IDLE, REPLAY, DONE}; REPLAY_GAP_W=8.
// - Instance of existing BRAM(width,depth) for storage.
// - One natural sub-module: adapter_from_bus (owidth->width assembler, enq/deq handshake,
//   inverse of the bus adapter used on capture readout).
// TESTING
// - Reset, push 4 words 0x1,0x2,0x3,0x4 -> loaded=2, entries 0x0000000200000001, 0x0000000400000003.
// - start count=2 gap=0 -> enable pulses with those two values in order, done one cycle after last.
// - start count=3 gap=3 with loaded=2 -> exactly 2 entries, >=3 idle cycles between, then done.
// - Push 2*depth+1 words -> loaded=depth, in.enq__RDY=0, last word not accepted.
// - 1 word pushed then start -> start__RDY=0; 2nd word -> start__RDY=1.
// - Assert RST mid-replay -> enable=0, done=0, loaded=0 next cycle; in.enq__RDY=1.

Source files
------------

// File: rtl/trace_replay_pkg.sv
// trace_replay_pkg: shared types and constants for the trace replay block.
package trace_replay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REPLAY,
        DONE
    } replay_state_t;

    localparam int REPLAY_GAP_W = 8;

endpackage

// File: rtl/trace_replay_adapter_from_bus.sv
// trace_replay_adapter_from_bus: gathers OWIDTH-bit bus words into WIDTH-bit entries, LS chunk first.
// Ports: clk_i/rst_i clock and sync reset; enq_ena_i/enq_v_i host word in; allow_i gates acceptance;
// enq_rdy_o word accepted this cycle; deq_ena_o/deq_v_o complete entry strobe; busy_o partial entry pending.
module trace_replay_adapter_from_bus #(
    parameter int OWIDTH = 32,
    parameter int WIDTH  = 64,
    localparam int N     = WIDTH / OWIDTH,
    localparam int NW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enq_ena_i,
    input  logic [OWIDTH-1:0] enq_v_i,
    input  logic              allow_i,
    output logic              enq_rdy_o,
    output logic              deq_ena_o,
    output logic [WIDTH-1:0]  deq_v_o,
    output logic              busy_o
);

    logic [NW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d, asm;
    logic             fire, last;

    assign enq_rdy_o = allow_i;
    assign fire      = enq_ena_i && allow_i;
    assign last      = cnt_q == NW'(N - 1);
    assign deq_ena_o = fire && last;
    assign deq_v_o   = asm;
    assign busy_o    = cnt_q != '0;

    // The completed entry is presented combinationally so the final chunk is written the cycle it arrives.
    always_comb begin
        asm = buf_q;
        asm[int'(cnt_q) * OWIDTH +: OWIDTH] = enq_v_i;
        buf_d = fire ? asm : buf_q;
        cnt_d = fire ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/trace_replay.sv
// trace_replay: loads host words into a replay buffer and replays them as an enable/data stream.
// Ports: clk_i/rst_i clock and sync reset; in_enq_ena_i/in_enq_v_i/in_enq_rdy_o host word handshake;
// start_ena_i/start_count_i/start_gap_i/start_rdy_o replay command; enable_o/data_o replayed stream;
// done_o end-of-replay pulse; loaded_o entries stored.
module trace_replay
    import trace_replay_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 64,
    parameter int OWIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_enq_ena_i,
    input  logic [OWIDTH-1:0]       in_enq_v_i,
    output logic                    in_enq_rdy_o,
    input  logic                    start_ena_i,
    input  logic [CW-1:0]           start_count_i,
    input  logic [REPLAY_GAP_W-1:0] start_gap_i,
    output logic                    start_rdy_o,
    output logic                    enable_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    done_o,
    output logic [CW-1:0]           loaded_o
);

    replay_state_t           state_q, state_d;
    logic [CW-1:0]           loaded_q, loaded_d, left_q, left_d;
    logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [REPLAY_GAP_W-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]        rd_data_q, rd_data_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [WIDTH-1:0]        wr_data;
    logic                    wr_en, busy, enq_allow, start_fire;

    assign enq_allow   = state_q == IDLE && loaded_q < CW'(DEPTH);
    assign start_rdy_o = state_q == IDLE && loaded_q != '0 && !busy;
    assign start_fire  = start_ena_i && start_rdy_o;
    assign enable_o    = rd_valid_q;
    assign data_o      = rd_data_q;
    assign done_o      = state_q == DONE;
    assign loaded_o    = loaded_q;

    trace_replay_adapter_from_bus #(
        .OWIDTH(OWIDTH),
        .WIDTH (WIDTH)
    ) u_adapter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enq_ena_i(in_enq_ena_i),
        .enq_v_i  (in_enq_v_i),
        .allow_i  (enq_allow),
        .enq_rdy_o(in_enq_rdy_o),
        .deq_ena_o(wr_en),
        .deq_v_o  (wr_data),
        .busy_o   (busy)
    );

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q] <= wr_data;
    end

    // Replay alternates read and emit cycles; the gap countdown sits between an emit and the next read.
    always_comb begin
        state_d    = state_q;
        loaded_d   = loaded_q + CW'(wr_en);
        wptr_d     = wptr_q + AW'(wr_en);
        rptr_d     = rptr_q;
        left_d     = left_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (state_q == IDLE && start_fire) begin
            state_d   = REPLAY;
            rptr_d    = '0;
            left_d    = (start_count_i == '0 || start_count_i > loaded_q) ? loaded_q : start_count_i;
            gap_d     = start_gap_i;
            gap_cnt_d = '0;
        end else if (state_q == REPLAY) begin
            if (rd_valid_q) begin
                state_d   = (left_q == '0) ? DONE : REPLAY;
                gap_cnt_d = gap_q;
            end else if (gap_cnt_q != '0) begin
                gap_cnt_d = gap_cnt_q - 1'b1;
            end else begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_q[rptr_q];
                rptr_d     = rptr_q + 1'b1;
                left_d     = left_q - 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            loaded_q   <= '0;
            left_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            loaded_q   <= loaded_d;
            left_q     <= left_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_trace_replay.sv
// tb_trace_replay: randomized self-checking bench for trace_replay against an entry-level model.
module tb_trace_replay;

    localparam int DEPTH = 1024;
    localparam int CW    = 11;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          in_enq_ena_i;
    logic [31:0]   in_enq_v_i;
    logic          in_enq_rdy_o;
    logic          start_ena_i;
    logic [CW-1:0] start_count_i;
    logic [7:0]    start_gap_i;
    logic          start_rdy_o;
    logic          enable_o;
    logic [63:0]   data_o;
    logic          done_o;
    logic [CW-1:0] loaded_o;

    int tests = 0;
    int fails = 0;

    logic [63:0] model_mem [DEPTH];
    int          model_loaded, model_wptr, model_cnt;
    logic [31:0] model_lo;
    int          dut_accepts;

    always #5 clk = ~clk;

    trace_replay dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .in_enq_ena_i (in_enq_ena_i),
        .in_enq_v_i   (in_enq_v_i),
        .in_enq_rdy_o (in_enq_rdy_o),
        .start_ena_i  (start_ena_i),
        .start_count_i(start_count_i),
        .start_gap_i  (start_gap_i),
        .start_rdy_o  (start_rdy_o),
        .enable_o     (enable_o),
        .data_o       (data_o),
        .done_o       (done_o),
        .loaded_o     (loaded_o)
    );

    task automatic model_reset();
        model_loaded = 0;
        model_wptr   = 0;
        model_cnt    = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        bit exp_rdy;
        exp_rdy      = model_loaded < DEPTH;
        in_enq_ena_i = 1'b1;
        in_enq_v_i   = w;
        tests++;
        if (in_enq_rdy_o !== exp_rdy) begin
            fails++;
            $display("FAIL enq_rdy: got %b expected %b (loaded %0d)", in_enq_rdy_o, exp_rdy, model_loaded);
        end
        if (in_enq_rdy_o === 1'b1) dut_accepts++;
        @(posedge clk);
        #1;
        in_enq_ena_i = 1'b0;
        if (exp_rdy) begin
            if (model_cnt == 0) begin
                model_lo  = w;
                model_cnt = 1;
            end else begin
                model_mem[model_wptr] = {w, model_lo};
                model_wptr   = (model_wptr + 1) % DEPTH;
                model_loaded = model_loaded + 1;
                model_cnt    = 0;
            end
        end
    endtask

    task automatic check_loaded(input string name);
        tests++;
        if (loaded_o !== CW'(model_loaded)) begin
            fails++;
            $display("FAIL %s loaded: got %0d expected %0d", name, loaded_o, model_loaded);
        end
    endtask

    task automatic run_replay(input int cnt, input int gap);
        int exp_n, got, last_en, cyc, budget;
        bit seen_done;
        exp_n     = (cnt == 0 || cnt > model_loaded) ? model_loaded : cnt;
        got       = 0;
        last_en   = -1000;
        cyc       = 0;
        seen_done = 1'b0;
        budget    = exp_n * (gap + 3) + 20;
        tests++;
        if (start_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL start_rdy before replay: got %b expected 1", start_rdy_o);
        end
        start_ena_i   = 1'b1;
        start_count_i = CW'(cnt);
        start_gap_i   = 8'(gap);
        @(posedge clk);
        #1;
        start_ena_i = 1'b0;
        tests++;
        if (in_enq_rdy_o !== 1'b0 || start_rdy_o !== 1'b0) begin
            fails++;
            $display("FAIL busy handshakes: enq_rdy %b start_rdy %b expected 0 0", in_enq_rdy_o, start_rdy_o);
        end
        while (!seen_done && cyc < budget) begin
            if (enable_o === 1'b1 && done_o === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL enable_with_done at cycle %0d", cyc);
            end
            if (enable_o === 1'b1) begin
                tests++;
                if (data_o !== model_mem[got % DEPTH] || (got > 0 && cyc - last_en < gap + 1)) begin
                    fails++;
                    $display("FAIL entry %0d: data %h expected %h, spacing %0d needs >= %0d",
                             got, data_o, model_mem[got % DEPTH], cyc - last_en, gap + 1);
                end
                last_en = cyc;
                got++;
            end
            if (done_o === 1'b1) begin
                seen_done = 1'b1;
                tests++;
                if (got != exp_n || cyc != last_en + 1 || data_o !== model_mem[(exp_n - 1) % DEPTH]) begin
                    fails++;
                    $display("FAIL done: entries %0d expected %0d, done at %0d expected %0d, data %h",
                             got, exp_n, cyc, last_en + 1, data_o);
                end
            end
            if (!seen_done) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!seen_done) begin
            tests++;
            fails++;
            $display("FAIL replay timeout: %0d entries after %0d cycles, expected %0d then done", got, cyc, exp_n);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done_o !== 1'b0 || enable_o !== 1'b0 || start_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL after done: done %b enable %b start_rdy %b expected 0 0 1", done_o, enable_o, start_rdy_o);
        end
        check_loaded("after replay");
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        tests++;
        if (enable_o !== 1'b0 || done_o !== 1'b0 || data_o !== 64'h0 || in_enq_rdy_o !== 1'b1 || start_rdy_o !== 1'b0) begin
            fails++;
            $display("FAIL reset: enable %b done %b data %h enq_rdy %b start_rdy %b expected 0 0 0 1 0",
                     enable_o, done_o, data_o, in_enq_rdy_o, start_rdy_o);
        end
        check_loaded("reset");
    endtask

    task automatic test_assembly();
        for (int i = 1; i <= 4; i++) push_word(32'(i));
        check_loaded("assembly");
        tests++;
        if (model_mem[0] !== 64'h0000000200000001 || model_mem[1] !== 64'h0000000400000003) begin
            fails++;
            $display("FAIL model assembly: %h %h", model_mem[0], model_mem[1]);
        end
    endtask

    task automatic test_replay_gap0();
        run_replay(2, 0);
    endtask

    task automatic test_clamp();
        run_replay(3, 3);
        run_replay(0, 1);
    endtask

    task automatic test_partial();
        push_word($urandom);
        tests++;
        if (start_rdy_o !== 1'b0) begin
            fails++;
            $display("FAIL partial start_rdy: got %b expected 0", start_rdy_o);
        end
        start_ena_i   = 1'b1;
        start_count_i = CW'(1);
        start_gap_i   = 8'd0;
        @(posedge clk);
        #1;
        start_ena_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (enable_o !== 1'b0 || in_enq_rdy_o !== 1'b1) begin
                fails++;
                $display("FAIL ignored start: enable %b enq_rdy %b expected 0 1", enable_o, in_enq_rdy_o);
            end
            @(posedge clk);
            #1;
        end
        push_word($urandom);
        tests++;
        if (start_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL completed start_rdy: got %b expected 1", start_rdy_o);
        end
        check_loaded("partial");
        run_replay(0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n;
            test_reset();
            n = $urandom_range(1, 12);
            for (int i = 0; i < 2 * n; i++) push_word($urandom);
            check_loaded("random load");
            run_replay($urandom_range(0, n + 3), $urandom_range(0, 4));
        end
    endtask

    task automatic test_full();
        test_reset();
        dut_accepts = 0;
        for (int i = 0; i < 2 * DEPTH + 1; i++) push_word($urandom);
        check_loaded("full");
        tests++;
        if (in_enq_rdy_o !== 1'b0 || dut_accepts != 2 * DEPTH) begin
            fails++;
            $display("FAIL full: enq_rdy %b accepted %0d expected 0 %0d", in_enq_rdy_o, dut_accepts, 2 * DEPTH);
        end
        run_replay(0, 0);
    endtask

    task automatic test_reset_mid();
        int waited;
        test_reset();
        for (int i = 0; i < 8; i++) push_word($urandom);
        start_ena_i   = 1'b1;
        start_count_i = CW'(0);
        start_gap_i   = 8'd5;
        @(posedge clk);
        #1;
        start_ena_i = 1'b0;
        waited = 0;
        while (enable_o !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        tests++;
        if (enable_o !== 1'b1) begin
            fails++;
            $display("FAIL mid replay enable: none within %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        tests++;
        if (enable_o !== 1'b0 || done_o !== 1'b0 || in_enq_rdy_o !== 1'b1) begin
            fails++;
            $display("FAIL reset mid replay: enable %b done %b enq_rdy %b expected 0 0 1", enable_o, done_o, in_enq_rdy_o);
        end
        check_loaded("reset mid replay");
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (enable_o !== 1'b0 || done_o !== 1'b0) begin
                fails++;
                $display("FAIL stream after reset: enable %b done %b expected 0 0", enable_o, done_o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_i         = 1'b1;
        in_enq_ena_i  = 1'b0;
        in_enq_v_i    = '0;
        start_ena_i   = 1'b0;
        start_count_i = '0;
        start_gap_i   = '0;
        dut_accepts   = 0;
        model_reset();
        test_reset();
        test_assembly();
        test_replay_gap0();
        test_clamp();
        test_partial();
        test_random();
        test_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
